// File: rtl/instr_bundle_queue_pkg.sv
// Shared types and helpers for the instruction bundle queue.
// Widths of an instruction, its word IP, and the four-slot prefetch bundle.
package instr_bundle_queue_pkg;

    localparam int IP_W    = 35;
    localparam int INSTR_W = 32;
    localparam int SLOTS   = 4;

    typedef struct packed {
        logic [IP_W-1:0]    ip;
        logic [INSTR_W-1:0] instr;
    } ibq_entry_t;

    localparam int ENTRY_W = $bits(ibq_entry_t);

    // Lane 0 sits in the least significant bits.
    typedef ibq_entry_t [SLOTS-1:0] ibq_lanes_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/ibq_compact.sv
// Squeezes the valid slots of one prefetch bundle into dense lanes, lowest slot first,
// tagging lane j with RIP + j.
module ibq_compact
    import instr_bundle_queue_pkg::*;
(
    input  logic [SLOTS-1:0]         vf,
    input  logic [SLOTS*INSTR_W-1:0] ibus,
    input  logic [IP_W-1:0]          rip,
    output logic [2:0]               n,
    output ibq_lanes_t               lanes
);

    logic [2:0] cnt;

    always_comb begin
        lanes = '0;
        cnt   = 3'd0;
        for (int k = 0; k < SLOTS; k++) begin
            if (vf[k]) begin
                lanes[cnt[1:0]].instr = ibus[k*INSTR_W +: INSTR_W];
                lanes[cnt[1:0]].ip    = rip + IP_W'(cnt);
                cnt                   = cnt + 3'd1;
            end
        end
    end

    assign n = popcount4(vf);

endmodule

// File: rtl/instr_bundle_queue.sv
// In-order queue of single instructions fed by four-slot prefetch bundles.
// Optional build macro IBQ_BYPASS_EN: an empty queue forwards the incoming bundle's first slot straight to the head.
module instr_bundle_queue
    import instr_bundle_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LW    = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     IRDY,
    input  logic [SLOTS-1:0]         VF,
    input  logic [SLOTS*INSTR_W-1:0] IBUS,
    input  logic [IP_W-1:0]          RIP,
    input  logic                     ERST,
    input  logic                     ITAKE,
    output logic                     IFETCH,
    output logic                     IVALID,
    output logic [INSTR_W-1:0]       INSTR,
    output logic [IP_W-1:0]          IIP,
    output logic [LW:0]              LEVEL,
    output logic                     EMPTY
);

    if (LW != $clog2(DEPTH) || DEPTH < 4 || (1 << LW) != DEPTH) begin : g_param_check
        $error("instr_bundle_queue: DEPTH must be a power of two >= 4 and LW == log2(DEPTH)");
    end

    // Handshakes: a bundle transfers on a rising edge where IRDY and IFETCH are both high
    // (IFETCH never looks at IRDY); the head entry retires on a rising edge where IVALID
    // and ITAKE are both high. Either side may hold its request for any number of cycles.

    localparam logic [LW:0] FILL_MAX = (LW+1)'(DEPTH - SLOTS);

    ibq_entry_t    mem [DEPTH];
    logic [LW-1:0] wptr;
    logic [LW-1:0] rptr;
    logic [LW:0]   level;

    logic [2:0]    n;
    ibq_lanes_t    lanes;
    ibq_lanes_t    wlanes;
    logic          fifo_valid;
    logic          accept;
    logic          pop;
    logic          byp_valid;
    logic          skip;
    logic [2:0]    n_store;
    logic [2:0]    add;
    ibq_entry_t    head;

    ibq_compact u_compact (
        .vf    (VF),
        .ibus  (IBUS),
        .rip   (RIP),
        .n     (n),
        .lanes (lanes)
    );

    assign fifo_valid = (level != '0);
    assign IFETCH     = RESET & ~ERST & (level <= FILL_MAX);
    assign accept     = IRDY & IFETCH;
    assign pop        = fifo_valid & ITAKE & ~ERST;

`ifdef IBQ_BYPASS_EN
    // An empty queue hands lane 0 straight to the decoder; if it is taken, it is never stored.
    assign byp_valid = ~fifo_valid & accept & (n != 3'd0);
    assign skip      = byp_valid & ITAKE;
`else
    assign byp_valid = 1'b0;
    assign skip      = 1'b0;
`endif

    assign n_store = n - {2'b00, skip};
    assign add     = accept ? n_store : 3'd0;
    assign wlanes  = skip ? ibq_lanes_t'(lanes >> ENTRY_W) : lanes;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (ERST) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + LW'(add);
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level + (LW+1)'(add) - (LW+1)'(pop);
        end
    end

    // Storage carries no reset; contents are only observable through rptr/level.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int j = 0; j < SLOTS; j++) begin
                if (3'(j) < n_store) begin
                    mem[wptr + LW'(j)] <= wlanes[j];
                end
            end
        end
    end

    assign head   = mem[rptr];
    assign IVALID = fifo_valid | byp_valid;
    assign INSTR  = byp_valid ? lanes[0].instr : head.instr;
    assign IIP    = byp_valid ? lanes[0].ip    : head.ip;
    assign LEVEL  = level;
    assign EMPTY  = ~fifo_valid;

endmodule

// File: tb/tb_instr_bundle_queue.sv
// Directed and scoreboarded bench for instr_bundle_queue (DEPTH=8).
// Honours IBQ_BYPASS_EN where the expected head timing differs.
module tb_instr_bundle_queue;
    import instr_bundle_queue_pkg::*;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         IRDY;
    logic [3:0]   VF;
    logic [127:0] IBUS;
    logic [34:0]  RIP;
    logic         ERST;
    logic         ITAKE;
    logic         IFETCH;
    logic         IVALID;
    logic [31:0]  INSTR;
    logic [34:0]  IIP;
    logic [3:0]   LEVEL;
    logic         EMPTY;

    int n_vec = 0;
    int n_err = 0;
    logic [66:0] exp_q[$];

    always #5 CLK = ~CLK;

    instr_bundle_queue #(.DEPTH(8), .LW(3)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .IRDY   (IRDY),
        .VF     (VF),
        .IBUS   (IBUS),
        .RIP    (RIP),
        .ERST   (ERST),
        .ITAKE  (ITAKE),
        .IFETCH (IFETCH),
        .IVALID (IVALID),
        .INSTR  (INSTR),
        .IIP    (IIP),
        .LEVEL  (LEVEL),
        .EMPTY  (EMPTY)
    );

    task automatic chk(input string tag, input logic [66:0] act, input logic [66:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IRDY  = 1'b0;
        VF    = 4'h0;
        IBUS  = '0;
        RIP   = '0;
        ERST  = 1'b0;
        ITAKE = 1'b0;
    endtask

    task automatic bundle(input logic [3:0] vf, input logic [127:0] ibus, input logic [34:0] rip);
        IRDY = 1'b1;
        VF   = vf;
        IBUS = ibus;
        RIP  = rip;
    endtask

    task automatic take_check(input string tag, input logic [31:0] ins, input logic [34:0] ip);
        ITAKE = 1'b1;
        #1;
        chk({tag, "_ivalid"}, 67'(IVALID), 67'(1));
        chk({tag, "_head"}, {IIP, INSTR}, {ip, ins});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first;
        int done;
        int cycles;
        int j;
        logic acc;
        logic byp_take;
        logic exp_iv;
        logic [66:0] e;

        // reset values
        RESET = 1'b0;
        idle();
        #12;
        chk("rst_level", 67'(LEVEL), 67'(0));
        chk("rst_empty", 67'(EMPTY), 67'(1));
        chk("rst_ivalid", 67'(IVALID), 67'(0));
        chk("rst_ifetch", 67'(IFETCH), 67'(0));
        RESET = 1'b1;
        step();

        // full bundle, consumed in order
        bundle(4'hF, {32'h4, 32'h3, 32'h2, 32'h1}, 35'h100);
        ITAKE = 1'b1;
        #1;
        chk("t1_ifetch", 67'(IFETCH), 67'(1));
`ifdef IBQ_BYPASS_EN
        chk("t1_byp_ivalid", 67'(IVALID), 67'(1));
        chk("t1_byp_head", {IIP, INSTR}, {35'h100, 32'h1});
        first = 1;
`else
        chk("t1_ivalid_lat", 67'(IVALID), 67'(0));
        first = 0;
`endif
        step();
        IRDY = 1'b0;
        VF   = 4'h0;
        for (int k = first; k < 4; k++) begin
            #1;
            chk("t1_level", 67'(LEVEL), 67'(4 - k));
            chk("t1_head", {IIP, INSTR}, {35'h100 + 35'(k), 32'(k + 1)});
            step();
        end
        #1;
        chk("t1_level_end", 67'(LEVEL), 67'(0));
        chk("t1_empty_end", 67'(EMPTY), 67'(1));
        chk("t1_ivalid_end", 67'(IVALID), 67'(0));
        idle();

        // holes compacted, IP wraps
        bundle(4'b1010, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 35'h7FFFFFFFF);
        step();
        IRDY = 1'b0;
        VF   = 4'h0;
        #1;
        chk("t2_level", 67'(LEVEL), 67'(2));
        take_check("t2_a", 32'hBBBB0001, 35'h7FFFFFFFF);
        take_check("t2_b", 32'hDDDD0003, 35'h0);
        #1;
        chk("t2_level_end", 67'(LEVEL), 67'(0));
        idle();

        // full queue holds off the third bundle
        bundle(4'hF, {32'h13, 32'h12, 32'h11, 32'h10}, 35'h200);
        step();
        bundle(4'hF, {32'h23, 32'h22, 32'h21, 32'h20}, 35'h204);
        #1;
        chk("t3_level4", 67'(LEVEL), 67'(4));
        chk("t3_ifetch4", 67'(IFETCH), 67'(1));
        step();
        bundle(4'hF, {32'h33, 32'h32, 32'h31, 32'h30}, 35'h208);
        #1;
        chk("t3_level8", 67'(LEVEL), 67'(8));
        chk("t3_ifetch8", 67'(IFETCH), 67'(0));
        step();
        #1;
        chk("t3_held_level", 67'(LEVEL), 67'(8));
        ITAKE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ifetch_full", 67'(IFETCH), 67'(0));
            chk("t3_pop_head", {IIP, INSTR}, {35'h200 + 35'(k), 32'h10 + 32'(k)});
            step();
        end
        #1;
        chk("t3_level_after_pops", 67'(LEVEL), 67'(4));
        chk("t3_ifetch_reopen", 67'(IFETCH), 67'(1));
        chk("t3_head20", {IIP, INSTR}, {35'h204, 32'h20});
        step();
        IRDY = 1'b0;
        VF   = 4'h0;
        #1;
        chk("t3_level7", 67'(LEVEL), 67'(7));
        for (int k = 0; k < 7; k++) begin
            take_check("t3_drain", (k < 3) ? 32'h21 + 32'(k) : 32'h30 + 32'(k - 3), 35'h205 + 35'(k));
        end
        #1;
        chk("t3_level_end", 67'(LEVEL), 67'(0));
        idle();

        // flush at LEVEL=5 with a coincident bundle and take
        bundle(4'hF, {32'h53, 32'h52, 32'h51, 32'h50}, 35'h300);
        step();
        bundle(4'h1, {96'h0, 32'h54}, 35'h304);
        step();
        bundle(4'hF, {32'h63, 32'h62, 32'h61, 32'h60}, 35'h400);
        ERST  = 1'b1;
        ITAKE = 1'b1;
        #1;
        chk("t4_level5", 67'(LEVEL), 67'(5));
        chk("t4_ifetch_erst", 67'(IFETCH), 67'(0));
        step();
        idle();
        #1;
        chk("t4_level_flush", 67'(LEVEL), 67'(0));
        chk("t4_ivalid_flush", 67'(IVALID), 67'(0));
        chk("t4_empty_flush", 67'(EMPTY), 67'(1));
        step();
        #1;
        chk("t4_not_stored", 67'(LEVEL), 67'(0));

        // asynchronous reset mid-operation
        bundle(4'hF, {32'h73, 32'h72, 32'h71, 32'h70}, 35'h500);
        step();
        IRDY = 1'b0;
        VF   = 4'h0;
        #1;
        chk("t5_level_pre", 67'(LEVEL), 67'(4));
        RESET = 1'b0;
        #1;
        chk("t5_async_level", 67'(LEVEL), 67'(0));
        chk("t5_async_ifetch", 67'(IFETCH), 67'(0));
        chk("t5_async_ivalid", 67'(IVALID), 67'(0));
        #2;
        RESET = 1'b1;
        step();
        #1;
        chk("t5_level_post", 67'(LEVEL), 67'(0));
        idle();

        // random bundles against a scoreboard, pointers wrap
        exp_q.delete();
        done   = 0;
        cycles = 0;
        while (done < 20 && cycles < 400) begin
            if (!IRDY) begin
                VF   = 4'($urandom_range(0, 15));
                IBUS = {$urandom, $urandom, $urandom, $urandom};
                RIP  = {3'($urandom_range(0, 7)), 32'($urandom)};
                IRDY = 1'b1;
            end
            ITAKE = 1'($urandom_range(0, 1));
            #1;
            acc    = (exp_q.size() <= 4);
            exp_iv = (exp_q.size() != 0);
`ifdef IBQ_BYPASS_EN
            if (exp_q.size() == 0 && acc && VF != 4'h0) exp_iv = 1'b1;
`endif
            chk("rnd_level", 67'(LEVEL), 67'(exp_q.size()));
            chk("rnd_level_max", 67'(LEVEL <= 4'd8), 67'(1));
            chk("rnd_ifetch", 67'(IFETCH), 67'(acc));
            chk("rnd_ivalid", 67'(IVALID), 67'(exp_iv));
            byp_take = 1'b0;
            if (ITAKE && exp_q.size() != 0) begin
                chk("rnd_head", {IIP, INSTR}, exp_q[0]);
                void'(exp_q.pop_front());
            end else if (ITAKE && exp_iv) begin
                byp_take = 1'b1;
            end
            if (acc) begin
                j = 0;
                for (int k = 0; k < 4; k++) begin
                    if (VF[k]) begin
                        e = {RIP + 35'(j), IBUS[k*32 +: 32]};
                        if (byp_take && j == 0) chk("rnd_bypass", {IIP, INSTR}, e);
                        else exp_q.push_back(e);
                        j++;
                    end
                end
                done++;
            end
            step();
            if (acc) IRDY = 1'b0;
            cycles++;
        end
        chk("rnd_bundles_done", 67'(done), 67'(20));
        idle();
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            ITAKE = 1'b1;
            #1;
            chk("rnd_drain", {IIP, INSTR}, exp_q[0]);
            void'(exp_q.pop_front());
            step();
            cycles++;
        end
        ITAKE = 1'b0;
        #1;
        chk("rnd_level_end", 67'(LEVEL), 67'(0));

        // single-slot bundle into an empty queue with ITAKE high
        bundle(4'h1, {96'h0, 32'hCAFE0001}, 35'h600);
        ITAKE = 1'b1;
        #1;
`ifdef IBQ_BYPASS_EN
        chk("t6_byp_ivalid", 67'(IVALID), 67'(1));
        chk("t6_byp_head", {IIP, INSTR}, {35'h600, 32'hCAFE0001});
        step();
        idle();
        #1;
        chk("t6_byp_level", 67'(LEVEL), 67'(0));
        chk("t6_byp_ivalid_after", 67'(IVALID), 67'(0));
`else
        chk("t6_ivalid_same", 67'(IVALID), 67'(0));
        step();
        IRDY = 1'b0;
        VF   = 4'h0;
        #1;
        chk("t6_level", 67'(LEVEL), 67'(1));
        chk("t6_ivalid_next", 67'(IVALID), 67'(1));
        chk("t6_head", {IIP, INSTR}, {35'h600, 32'hCAFE0001});
        step();
        idle();
        #1;
        chk("t6_level_end", 67'(LEVEL), 67'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_bundle_queue.md
Name: instr_bundle_queue

Overview:
- Downstream of the instruction prefetcher; consumes its 128-bit four-slot bundle (IBUS, VF, IRDY) and drives its IFETCH.
- Compacts valid slots into an in-order FIFO of single 32-bit instructions, each tagged with its 35-bit word IP.
- Presents one instruction per cycle to the decoder/sequencer and flushes on near-jump restart (ERST).

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- LW, 3, log2(DEPTH); must equal log2(DEPTH), checked by elaboration assertion.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous active-low reset
- IRDY  in  1  bundle valid from prefetcher
- VF  in  4  per-slot valid; slot k = IBUS[32k+31:32k]
- IBUS  in  128  instruction bundle
- RIP  in  35  word IP of lowest valid slot of current bundle
- ERST  in  1  flush pulse (near jump / restart)
- ITAKE  in  1  decoder consumes head entry
- IFETCH  out  1  bundle accept strobe to prefetcher
- IVALID  out  1  head entry valid
- INSTR  out  32  head instruction
- IIP  out  35  head instruction IP
- LEVEL  out  LW+1  occupancy 0..DEPTH
- EMPTY  out  1  LEVEL==0

Behaviour:
- Reset (RESET low, asynchronous): write pointer, read pointer and count cleared. LEVEL=0, EMPTY=1, IVALID=0, IFETCH=0. INSTR/IIP are don't-care.
- Storage: DEPTH x 67-bit entries {IP[34:0], instr[31:0]}; pointers wrap modulo DEPTH.
- IFETCH is combinational: (DEPTH-LEVEL >= 4) & ~ERST. It never depends on IRDY.
- Accept: IRDY & IFETCH at rising edge.
  - n = popcount(VF), 0..4; n=0 accepts and discards the bundle.
  - Valid slots are written in ascending slot order to wptr, wptr+1, ... The j-th valid slot (j=0..n-1) gets IP = RIP + j, 35-bit wrap.
  - VF holes are legal and are compacted out.
  - wptr advances by n.
- Pop: IVALID & ITAKE advances rptr by 1. ITAKE while IVALID=0 is ignored.
- Count: LEVEL_next = LEVEL + n·accept − pop. Simultaneous accept and pop in one cycle is legal. The LEVEL>=4 free check guarantees no overflow.
- Output: IVALID = (LEVEL!=0); INSTR/IIP = entry at rptr. Both are registered storage reads, combinationally addressed.
- Latency: a bundle accepted at edge N shows its first instruction on IVALID after edge N, i.e. the next cycle.
- Flush:
  - ERST high at an edge sets wptr=rptr=0 and LEVEL=0.
  - Any concurrent bundle is not accepted (IFETCH already low).
  - Any concurrent ITAKE has no further effect.
  - IVALID=0 the cycle after.
- Full: LEVEL > DEPTH-4 holds IFETCH low. The prefetcher holds its bundle until IFETCH is high.
- Empty: IVALID=0, EMPTY=1, ITAKE ignored.
- Reset mid-operation discards all contents; no partial bundle survives.

Optional Feature:
- Macro IBQ_BYPASS_EN.
- Defined:
  - When LEVEL==0 and IRDY & IFETCH & (VF!=0), IVALID rises in the same cycle.
  - INSTR/IIP show the lowest valid slot and RIP combinationally.
  - If ITAKE is also high, that slot is not written to the FIFO; the remaining n−1 slots are stored.
  - ERST still forces IVALID=0 combinationally.
- Undefined: behaviour exactly as above, one-cycle minimum latency, no combinational IRDY→IVALID path.

Decomposition:
- Package instr_bundle_queue_pkg:
  - IP_W=35, INSTR_W=32, SLOTS=4.
  - typedef ibq_entry_t {ip, instr}.
  - function popcount4.
- Sub-module ibq_compact: combinational.
  - Inputs VF, IBUS, RIP.
  - Outputs count n and four packed ibq_entry_t lanes (lane j = j-th valid slot, IP=RIP+j).
  - The top level writes lanes 0..n-1 at wptr+j.

Test Plan:
- After reset, IRDY=1, VF=4'hF, IBUS={32'h4,32'h3,32'h2,32'h1}, RIP=35'h100, ITAKE=1 → IVALID next cycle. INSTR sequence 1,2,3,4 with IIP 100,101,102,103. LEVEL returns to 0.
- VF=4'b1010, RIP=35'h7FFFFFFFF → two entries: slot1 instr with IP 7FFFFFFFF, slot3 instr with IP 0 (wrap). Check compaction and IP wrap.
- ITAKE=0, DEPTH=8, two full bundles accepted → LEVEL=8, IFETCH=0. Third bundle held. After 4 pops (LEVEL=4) IFETCH=1 and the third bundle is accepted.
- LEVEL=5 with ERST pulse coincident with IRDY & ITAKE → IFETCH=0 that cycle. Next cycle LEVEL=0, IVALID=0; bundle not stored.
- Pointer wrap: 20 bundles with random VF and random ITAKE → scoreboard order/IP match. LEVEL never exceeds 8.
- With IBQ_BYPASS_EN: empty queue, VF=4'h1, ITAKE=1 → IVALID=1 same cycle, LEVEL stays 0. Without the macro, IVALID rises one cycle later.
